// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// hex glyph table, pin-polarity helpers and counter-width sizing.
package seg7_pkg;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_on(input logic [6:0] pattern, input bit active_low);
    return active_low ? ~pattern : pattern;
  endfunction

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic pin_level(input logic on, input bit active_low);
    return on ^ active_low;
  endfunction

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with PWM brightness, per-digit
// blank/dp, double-buffered frame-aligned updates and a frame-done pulse.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DUTY_W         = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [DUTY_W-1:0]       brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV_W   = cnt_width(CLK_DIV);
  localparam int IDX_W   = cnt_width(NUM_DIGITS);
  localparam int SUB_LEN = CLK_DIV >> DUTY_W;
  localparam bit SEG_AL  = (SEG_ACTIVE_LOW != 0);
  localparam bit AN_AL   = (AN_ACTIVE_LOW != 0);

  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_AL ? '1 : '0;

  // Scan state
  logic [DIV_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_end;

  // Pending (written by load) and active (displayed) buffers
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_blank,  act_blank;
  logic [NUM_DIGITS-1:0]   pend_dp,     act_dp;

  // Per-cycle decode of the digit under the scan
  int                    cur;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_pat;
  logic [DUTY_W-1:0]     sub_phase;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_end  = (pre == DIV_W'(CLK_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= slot_end ? '0 : pre + 1'b1;
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + 1'b1;
      end
    end
  end

  // load is a valid-only strobe: it is always accepted, there is no ready,
  // and the latest strobe before a frame boundary is the one displayed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_digits <= '0;
      pend_blank  <= '1;
      pend_dp     <= '0;
    end else if (load) begin
      pend_digits <= digits_in;
      pend_blank  <= blank_in;
      pend_dp     <= dp_in;
    end
  end

  // Active takes the pre-edge pending value, so a load on the boundary
  // cycle lands one frame later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_digits <= '0;
      act_blank  <= '1;
      act_dp     <= '0;
    end else if (frame_end) begin
      act_digits <= pend_digits;
      act_blank  <= pend_blank;
      act_dp     <= pend_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
    end
  end

  seg7_hex_decode u_dec (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  // Prescaler value 0 is kept dark as a dead cycle between digits.
  always_comb begin
    cur       = int'(idx);
    cur_nib   = act_digits[cur*4 +: 4];
    sub_phase = DUTY_W'(pre / DIV_W'(SUB_LEN));
    lit       = (sub_phase < brightness) && (pre != '0) && !act_blank[cur];
    an_onehot = lit ? (NUM_DIGITS'(1) << idx) : '0;
    an_next   = AN_AL ? ~an_onehot : an_onehot;
    seg_next  = lit ? seg_on(cur_pat, SEG_AL) : seg_off(SEG_AL);
    dp_next   = pin_level(lit && act_dp[cur], SEG_AL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= seg_off(SEG_AL);
      dp  <= pin_level(1'b0, SEG_AL);
      an  <= AN_OFF;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 16-cycle slots, 2-bit
// brightness, active-low segments and anodes.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks;
  int failures;

  // Patterns packed {slot3,slot2,slot1,slot0}; digit i sits in slot i.
  localparam logic [27:0] PAT_1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] PAT_ABCD = {7'h77, 7'h7C, 7'h39, 7'h5E};
  localparam logic [11:0] DARK     = {4'hF, 7'h7F, 1'b1};

  logic [3:0] obs_an  [0:199];
  logic [6:0] obs_seg [0:199];
  logic       obs_dp  [0:199];
  logic       obs_fd  [0:199];
  int         obs_n;

  seg7_scan_driver #(
    .NUM_DIGITS     (4),
    .CLK_DIV        (16),
    .DUTY_W         (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .load       (load),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

  // Driver tasks (called on a negedge, return on a negedge)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Records outputs cycle by cycle up to and including the frame_done cycle.
  task automatic cap();
    obs_n = 0;
    while (obs_n < 200) begin
      @(negedge clk);
      obs_an[obs_n]  = an;
      obs_seg[obs_n] = seg;
      obs_dp[obs_n]  = dp;
      obs_fd[obs_n]  = frame_done;
      obs_n++;
      if (frame_done) break;
    end
  endtask

  // Expected {an,seg,dp} for cycle k (1..64) of a frame, from the
  // hand-derived lit window: prescaler 1..lit_end of each non-blank slot.
  function automatic logic [11:0] exp_out(input int k, input logic [27:0] pats,
                                          input logic [3:0] blank, input logic [3:0] dps,
                                          input int lit_end);
    int         pre;
    int         slot;
    logic [3:0] onehot;
    pre    = (k - 1) % 16;
    slot   = (k - 1) / 16;
    onehot = 4'b0001 << slot;
    if (pre >= 1 && pre <= lit_end && !blank[slot])
      return {~onehot, ~pats[7*slot +: 7], ~dps[slot]};
    return DARK;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done} !== {DARK, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {an, seg, dp, frame_done}, {DARK, 1'b0});
    end
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cap();
      checks++;
      if (obs_n !== 64) begin
        failures++;
        $display("FAIL reset_frame_len frame=%0d got=%0d exp=64", f, obs_n);
      end
      for (int k = 1; k <= obs_n; k++) begin
        checks++;
        if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1], obs_fd[k-1]} !== {DARK, (k == 64)}) begin
          failures++;
          $display("FAIL reset_dark k=%0d got=%h exp=%h", k,
                   {obs_an[k-1], obs_seg[k-1], obs_dp[k-1], obs_fd[k-1]}, {DARK, (k == 64)});
        end
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [11:0] e;
    brightness = 2'd3;
    step(20);
    pulse_load(16'h1234, 4'b0000, 4'b0100);
    cap();
    checks++;
    if (obs_n !== 43) begin
      failures++;
      $display("FAIL midload_rest_len got=%0d exp=43", obs_n);
    end
    for (int k = 1; k <= obs_n; k++) begin
      checks++;
      if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== DARK) begin
        failures++;
        $display("FAIL midload_still_dark k=%0d got=%h exp=%h", k,
                 {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, DARK);
      end
    end
    cap();
    checks++;
    if (obs_n !== 64) begin
      failures++;
      $display("FAIL midload_frame_len got=%0d exp=64", obs_n);
    end
    for (int k = 1; k <= obs_n; k++) begin
      e = exp_out(k, PAT_1234, 4'b0000, 4'b0100, 11);
      checks++;
      if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== e) begin
        failures++;
        $display("FAIL midload_frame k=%0d got=%h exp=%h", k, {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, e);
      end
    end
  endtask

  task automatic test_brightness();
    logic [11:0] e;
    for (int b = 1; b >= 0; b--) begin
      brightness = 2'(b);
      cap();
      checks++;
      if (obs_n !== 64) begin
        failures++;
        $display("FAIL bright_frame_len b=%0d got=%0d exp=64", b, obs_n);
      end
      for (int k = 1; k <= obs_n; k++) begin
        e = exp_out(k, PAT_1234, 4'b0000, 4'b0100, (b == 1) ? 3 : 0);
        checks++;
        if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== e) begin
          failures++;
          $display("FAIL bright_%0d k=%0d got=%h exp=%h", b, k,
                   {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, e);
        end
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    step(10);
    pulse_load(16'h1234, 4'b0000, 4'b0100);
    step(52);
    // Now on the cycle whose rising edge is the frame boundary.
    pulse_load(16'hABCD, 4'b0000, 4'b0001);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL boundary_alignment frame_done got=%b exp=1", frame_done);
    end
    for (int f = 0; f < 2; f++) begin
      cap();
      checks++;
      if (obs_n !== 64) begin
        failures++;
        $display("FAIL boundary_frame_len frame=%0d got=%0d exp=64", f, obs_n);
      end
      for (int k = 1; k <= obs_n; k++) begin
        e = (f == 0) ? exp_out(k, PAT_1234, 4'b0000, 4'b0100, 11)
                     : exp_out(k, PAT_ABCD, 4'b0000, 4'b0001, 11);
        checks++;
        if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== e) begin
          failures++;
          $display("FAIL boundary_frame%0d k=%0d got=%h exp=%h", f, k,
                   {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, e);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [11:0] e;
    step(5);
    pulse_load(16'h1234, 4'b1010, 4'b0100);
    cap();
    checks++;
    if (obs_n !== 58) begin
      failures++;
      $display("FAIL blank_rest_len got=%0d exp=58", obs_n);
    end
    cap();
    checks++;
    if (obs_n !== 64) begin
      failures++;
      $display("FAIL blank_frame_len got=%0d exp=64", obs_n);
    end
    for (int k = 1; k <= obs_n; k++) begin
      e = exp_out(k, PAT_1234, 4'b1010, 4'b0100, 11);
      checks++;
      if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== e) begin
        failures++;
        $display("FAIL blank_frame k=%0d got=%h exp=%h", k, {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] e;
    step(40);
    checks++;
    if (an !== 4'b1011) begin
      failures++;
      $display("FAIL slot2_before_reset an got=%b exp=1011", an);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done} !== {DARK, 1'b0}) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=%h", {an, seg, dp, frame_done}, {DARK, 1'b0});
    end
    rst_n = 1'b1;
    cap();
    checks++;
    if (obs_n !== 64) begin
      failures++;
      $display("FAIL midreset_restart_len got=%0d exp=64", obs_n);
    end
    for (int k = 1; k <= obs_n; k++) begin
      checks++;
      if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== DARK) begin
        failures++;
        $display("FAIL midreset_dark k=%0d got=%h exp=%h", k, {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, DARK);
      end
    end
    step(5);
    pulse_load(16'h1234, 4'b0000, 4'b0100);
    cap();
    for (int k = 1; k <= obs_n; k++) begin
      checks++;
      if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== DARK) begin
        failures++;
        $display("FAIL midreset_pending_dark k=%0d got=%h exp=%h", k,
                 {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, DARK);
      end
    end
    cap();
    checks++;
    if (obs_n !== 64) begin
      failures++;
      $display("FAIL midreset_frame_len got=%0d exp=64", obs_n);
    end
    for (int k = 1; k <= obs_n; k++) begin
      e = exp_out(k, PAT_1234, 4'b0000, 4'b0100, 11);
      checks++;
      if ({obs_an[k-1], obs_seg[k-1], obs_dp[k-1]} !== e) begin
        failures++;
        $display("FAIL midreset_frame k=%0d got=%h exp=%h", k, {obs_an[k-1], obs_seg[k-1], obs_dp[k-1]}, e);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    digits_in  = '0;
    blank_in   = '0;
    dp_in      = '0;
    load       = 1'b0;
    brightness = 2'd3;
    test_reset();
    test_load_midframe();
    test_brightness();
    test_back_to_back();
    test_blank();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed seven-segment display driver.
- Next generation of the team's fixed 4-digit display mux.
- Adds digit-count, clock-division and output-polarity parameters, and per-digit blank and decimal-point control.
- Adds PWM brightness, double-buffered tear-free updates, an inter-digit dead cycle and a frame-done pulse.
- Sits between the datapath (counters, switch inputs) and the board's segment/anode pins, driven from the single system clock.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- CLK_DIV, 50000: clk cycles per digit slot. Must be a multiple of 2**DUTY_W and at least 2**DUTY_W.
- DUTY_W, 4: brightness resolution in bits.
- SEG_ACTIVE_LOW, 1: 1 means a segment lights at 0.
- AN_ACTIVE_LOW, 1: 1 means an anode enables at 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i is bits [4i+3:4i].
- blank_in  in  NUM_DIGITS  1 means digit i is dark.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- load  in  1  one-cycle strobe; captures digits_in, blank_in and dp_in into the pending buffer.
- brightness  in  DUTY_W  on-time in sub-phases per slot; 0 means dark.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0]=a.
- dp  out  1  decimal-point segment.
- an  out  NUM_DIGITS  digit enables; an[i] drives digit i.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, scan index=0.
  - Pending and active buffers: digits=0, blank=all 1, dp=0.
  - seg and dp driven to the "off" level; an all disabled (polarity per parameters); frame_done=0.
  - Reset mid-frame aborts the scan immediately. The display stays dark until the first load is applied.
- Prescaler: counts 0..CLK_DIV-1, then wraps to 0. A wrap is a slot end.
- Scan index:
  - Increments at each slot end; wraps from NUM_DIGITS-1 to 0.
  - The slot end where the index wraps is the frame boundary.
- frame_done: registered; high for exactly the one cycle after the frame-boundary edge.
- Double buffering:
  - load=1 overwrites the pending buffer. Multiple loads within a frame: last one wins.
  - The active buffer takes the pending buffer at the frame boundary.
  - If load coincides with the boundary cycle, the active buffer takes the previous pending contents. The new data appears one frame later.
- Brightness:
  - sub-phase = prescaler / (CLK_DIV >> DUTY_W), range 0..2**DUTY_W-1.
  - The digit is lit when sub-phase < brightness, the prescaler is not 0 (dead cycle against ghosting), and the active blank bit for the current digit is 0.
  - brightness=0 means always dark. The maximum is (2**DUTY_W-1)/2**DUTY_W of the slot minus the dead cycle.
  - brightness is sampled continuously, not buffered.
- Decode:
  - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Inverted when SEG_ACTIVE_LOW=1.
  - dp = active dp bit of the current digit, same polarity.
- Output timing:
  - seg, dp and an are registered. They reflect the prescaler and scan state of the previous cycle, so latency is 1 clk.
  - Exactly one or zero an bits are enabled at any time.
  - When the digit is unlit, seg and dp are also driven "off".

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF/SEG_ON polarity helper functions;
  - the function computing $clog2 widths for the prescaler and scan index.
- One combinational sub-module, seg7_hex_decode: nibble -> 7-bit active-high pattern.
- Scan, PWM and buffering stay in the top block.

Test Plan:
- Reset with NUM_DIGITS=4, CLK_DIV=16, DUTY_W=2, active-low outputs; hold rst_n=0 for 3 cycles, release, no load -> an=4'b1111 and seg=7'h7F for a full 64-cycle frame; frame_done pulses every 64 cycles.
- load digits_in=16'h1234, blank_in=0, dp_in=4'b0100, brightness=3 mid-frame -> no change until the next frame_done. Then:
  - during slot 0, an=4'b1110 with seg=~7'h66 (digit 4) for sub-phase cycles 1..11 of the slot and dark on cycles 0 and 12..15;
  - during slot 2, dp=0 (lit).
- brightness=1 -> each digit lit for exactly 3 cycles per slot (prescaler 1..3); brightness=0 -> an stays all-disabled.
- load asserted on the exact frame-boundary cycle with 16'hABCD, with pending 16'h1234 -> the next frame shows 1234; the frame after shows ABCD.
- blank_in=4'b1010 with brightness=3 -> digits 1 and 3 never enable an; digits 0 and 2 are lit normally.
- Assert rst_n=0 during slot 2 -> on the next edge an is all disabled, the scan restarts at digit 0, and the display stays dark until a new load is applied at a frame boundary.
